// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode boundary signals: fetch-side valid/ready entry plus decode-side
// stall, flush and the presented head entry.
interface fetch_decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    // Fetch handshake: an entry transfers on a rising edge where valid_i and
    // ready_o are both high and Flush_i is low; fetch holds its entry otherwise.
    logic [XLEN-1:0]        pc_i;
    logic [ILEN-1:0]        instr_i;
    logic                   valid_i;
    logic                   ready_o;
    logic                   Stall_i;
    logic                   Flush_i;
    logic [XLEN-1:0]        pc_o;
    logic [ILEN-1:0]        instr_o;
    logic                   valid_o;
    logic [$clog2(DEPTH):0] count_o;

    modport master (
        output pc_i, instr_i, valid_i, Stall_i, Flush_i,
        input  ready_o, pc_o, instr_o, valid_o, count_o
    );

    modport slave (
        input  pc_i, instr_i, valid_i, Stall_i, Flush_i,
        output ready_o, pc_o, instr_o, valid_o, count_o
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// IF/ID boundary FIFO of {pc, instr} entries. Flush beats stall, and the head
// is presented combinationally from registered storage.
module fetch_decode_queue #(
    parameter int              XLEN         = 32,
    parameter int              ILEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [ILEN-1:0] BUBBLE_INSTR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fetch_decode_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [ILEN-1:0] r_mem_instr [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Full/empty come only from the registered count, so ready/valid never
    // depend combinationally on any input.
    assign w_ready = (r_count != CW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_push  = bus.valid_i & w_ready & ~bus.Flush_i;
    assign w_pop   = w_valid & ~bus.Stall_i & ~bus.Flush_i;

    // Entry storage is never cleared; the count gates stale data off the outputs.
    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            r_mem_pc[r_wptr]    <= bus.pc_i;
            r_mem_instr[r_wptr] <= bus.instr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.Flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.valid_o = w_valid;
    assign bus.count_o = r_count;
    assign bus.pc_o    = w_valid ? r_mem_pc[r_rptr]    : '0;
    assign bus.instr_o = w_valid ? r_mem_instr[r_rptr] : BUBBLE_INSTR;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: a queue of expected {pc, instr}
// entries is filled as fetch offers are accepted and drained as decode pops.
module tb_fetch_decode_queue;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [ILEN-1:0] BUBBLE = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic acc;

    logic [XLEN+ILEN-1:0] exp_q[$];

    fetch_decode_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

    fetch_decode_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .BUBBLE_INSTR(BUBBLE)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: no summary after time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Registered outputs compared against the model state before this edge.
    task automatic check_state(input string tag);
        int sz;
        sz = exp_q.size();
        chk({tag, "_count"}, 64'(bus.count_o), 64'(sz));
        chk({tag, "_valid"}, 64'(bus.valid_o), 64'(sz != 0));
        chk({tag, "_ready"}, 64'(bus.ready_o), 64'(sz != DEPTH));
        chk({tag, "_le_depth"}, 64'(bus.count_o <= DEPTH), 64'(1));
        if (sz != 0) begin
            chk({tag, "_head"}, {bus.pc_o, bus.instr_o}, exp_q[0]);
        end else begin
            chk({tag, "_pc_bubble"}, 64'(bus.pc_o), 64'(0));
            chk({tag, "_instr_bubble"}, 64'(bus.instr_o), 64'(BUBBLE));
        end
    endtask

    // One clock: drive inputs at negedge, check, update the model, advance.
    task automatic cycle(input string tag, input logic v, input logic [XLEN-1:0] pc,
                         input logic stall, input logic flush, input logic r,
                         output logic accepted);
        logic [ILEN-1:0]      ins;
        logic [XLEN+ILEN-1:0] got;
        logic [XLEN+ILEN-1:0] exp;
        logic                 do_pop;
        logic                 do_push;
        ins         = $urandom();
        bus.valid_i = v;
        bus.pc_i    = pc;
        bus.instr_i = ins;
        bus.Stall_i = stall;
        bus.Flush_i = flush;
        rst         = r;
        #1;
        check_state(tag);
        accepted = 1'b0;
        if (r || flush) begin
            exp_q.delete();
        end else begin
            do_pop  = (exp_q.size() != 0) && !stall;
            do_push = v && (exp_q.size() < DEPTH);
            if (do_pop) begin
                got = {bus.pc_o, bus.instr_o};
                exp = exp_q.pop_front();
                chk({tag, "_pop"}, got, exp);
            end
            if (do_push) begin
                exp_q.push_back({pc, ins});
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int sent;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.valid_i = 1'b1;
        bus.pc_i    = 32'hDEAD_0000;
        bus.instr_i = 32'hFFFF_FFFF;
        bus.Stall_i = 1'b0;
        bus.Flush_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values, nothing captured while reset held with valid_i=1
        cycle("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

        // Streaming
        cycle("stream", 1'b1, 32'h00, 1'b0, 1'b0, 1'b0, acc);
        cycle("stream", 1'b1, 32'h04, 1'b0, 1'b0, 1'b0, acc);
        cycle("stream", 1'b1, 32'h08, 1'b0, 1'b0, 1'b0, acc);
        cycle("stream", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        cycle("stream_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

        // Fill under stall, offer while full, release
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fill", 1'b1, 32'h10 + 32'(4 * i), 1'b1, 1'b0, 1'b0, acc);
        end
        cycle("full_offer", 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, acc);
        chk("full_not_captured", 64'(acc), 64'(0));
        cycle("full_offer", 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, acc);
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            cycle("release", 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, acc);
        end
        chk("release_took_0x20", 64'(acc), 64'(1));
        repeat (6) cycle("drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

        // Flush beats stall and drops the concurrent push
        cycle("pre_flush", 1'b1, 32'h30, 1'b1, 1'b0, 1'b0, acc);
        cycle("pre_flush", 1'b1, 32'h34, 1'b1, 1'b0, 1'b0, acc);
        cycle("pre_flush", 1'b1, 32'h38, 1'b1, 1'b0, 1'b0, acc);
        cycle("flush", 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, acc);
        cycle("post_flush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        cycle("post_flush_push", 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, acc);
        cycle("post_flush_seen", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        cycle("post_flush_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

        // Wrap-around with alternating stall; fetch holds until accepted
        sent = 0;
        for (int c = 0; c < 40 && sent < 10; c++) begin
            cycle("wrap", 1'b1, 32'h100 + 32'(4 * sent), 1'(c % 2), 1'b0, 1'b0, acc);
            if (acc) sent++;
        end
        chk("wrap_all_sent", 64'(sent), 64'(10));
        repeat (6) cycle("wrap_drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

        // Mid-operation reset
        cycle("pre_rst", 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, acc);
        cycle("pre_rst", 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, acc);
        cycle("mid_rst", 1'b1, 32'h208, 1'b1, 1'b0, 1'b1, acc);
        cycle("after_rst_push", 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, acc);
        cycle("after_rst_alone", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        repeat (3) cycle("final_drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised IF/ID boundary buffer. A DEPTH-entry FIFO of {pc, instr} pairs decouples the fetch stage from decode, so fetch can keep issuing while decode stalls. It provides a valid/ready handshake on the fetch side, stall-held output on the decode side, and a one-cycle flush that discards every buffered instruction. It replaces the single-entry IF/ID register between the instruction-memory read port and the decoder/hazard unit.

## Interface
- XLEN, 32, width of the pc field.
- ILEN, 32, width of the instruction field.
- DEPTH, 4, number of buffered entries; power of two, ≥2.
- BUBBLE_INSTR, {ILEN{1'b0}}, value driven on instr_o when no valid entry is presented.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_i  in  XLEN  pc of the fetched instruction.
- instr_i  in  ILEN  fetched instruction.
- valid_i  in  1  fetch offers {pc_i, instr_i} this cycle.
- ready_o  out  1  queue accepts an entry this cycle; equals (count_o != DEPTH).
- Stall_i  in  1  decode cannot consume; head is held.
- Flush_i  in  1  discard all entries, including any entry offered this cycle.
- pc_o  out  XLEN  pc of the head entry.
- instr_o  out  ILEN  instruction of the head entry.
- valid_o  out  1  head entry is valid; equals (count_o != 0).
- count_o  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH-entry register array, plus a write pointer and a read pointer of $clog2(DEPTH) bits each, and an occupancy counter.
  - Pointers wrap modulo DEPTH by natural overflow.
  - The counter is the sole full/empty source.
- push = valid_i & ready_o & ~Flush_i. Writes {pc_i, instr_i} at wptr; wptr increments.
- pop = valid_o & ~Stall_i & ~Flush_i. rptr increments; the entry is consumed.
- Count update when neither reset nor flush:
  - push & ~pop: count +1.
  - pop & ~push: count −1.
  - both or neither: count unchanged.
- Priority, highest first: rst_i, Flush_i, normal push/pop.
  - Flush_i overrides Stall_i. This intentionally differs from the old stage register, where stall won.
- Flush: rptr, wptr and count clear to 0 on the next edge. A concurrent push is dropped; no pop occurs.
- Outputs:
  - Combinational reads of registered head storage, gated by valid_o.
  - valid_o=1: pc_o = mem[rptr].pc, instr_o = mem[rptr].instr.
  - valid_o=0: pc_o = 0, instr_o = BUBBLE_INSTR.
- Full (count=DEPTH): ready_o=0. valid_i is ignored; fetch must hold its entry. A pop in the same cycle still occurs, and ready_o reasserts on the following cycle (no same-cycle pass-through).
- Empty: no bypass. An entry pushed at edge N is visible on the outputs only after edge N.
- Stall with valid_o=1: pc_o and instr_o are held stable while pushes continue into free entries.
- Entry contents are never cleared by flush or reset. Only the pointers and count are cleared, and the output gating hides stale data.

## Timing
- Reset: sampled on a rising edge while rst_i=1. After that edge:
  - count_o=0, valid_o=0, ready_o=1, pc_o=0, instr_o=BUBBLE_INSTR.
  - Reset asserted mid-operation discards all entries exactly as flush does.
- Latency: fetch→decode is 1 cycle minimum when empty and unstalled. Throughput is 1 entry/cycle when unstalled.
- Flush asserted in cycle N: valid_o=0 and count_o=0 from cycle N+1. A push in cycle N+1 is visible in N+2.
- ready_o and valid_o depend only on registered count. There is no combinational path from any input to ready_o or valid_o.
- ready_o, valid_o and count_o never change except at a clock edge.

## Test plan
- Reset: hold rst_i=1 for 2 cycles with valid_i=1 → count_o=0, valid_o=0, ready_o=1, instr_o=BUBBLE_INSTR, pc_o=0; no entries captured.
- Streaming: push pc 0x00,0x04,0x08 on consecutive cycles with Stall_i=0 → same pcs on pc_o one cycle later each; count_o stays 1.
- Fill under stall:
  - Stall_i=1, push pcs 0x10..0x1C (DEPTH=4) → count_o=4, ready_o=0, pc_o=0x10 held.
  - Offer pc 0x20 while full → not captured.
  - Release stall → pops 0x10,0x14,0x18,0x1C in order; 0x20 accepted only once ready_o=1.
- Flush priority: count_o=3 with Stall_i=1, assert Flush_i and valid_i (pc 0x40) together → next cycle count_o=0, valid_o=0; 0x40 never appears.
- Wrap-around: push/pop 10 entries through DEPTH=4 with alternating stall → output order matches input order across pointer wrap; count_o never exceeds 4.
- Mid-operation reset: count_o=2, assert rst_i one cycle → all outputs at reset values; the next push appears alone with count_o=1.
